// File: rtl/tt_macro_bist_sequencer_if.sv
// Bus bundle between the TT user-tile pins and the macro BIST sequencer.
// slave = sequencer side, master = tile/test side.
interface tt_macro_bist_sequencer_if #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     start;
    logic [SEL_W-1:0]         ch_sel;
    logic [CNT_W-1:0]         vec_cnt;
    logic [DATA_W-1:0]        seed;
    logic [DATA_W-1:0]        exp_sig;
    logic [N_CH*DATA_W-1:0]   stim;
    logic [N_CH-1:0]          ch_en;
    logic [N_CH*DATA_W-1:0]   resp;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [DATA_W-1:0]        sig;

    modport master (
        output start, ch_sel, vec_cnt, seed, exp_sig, resp,
        input  stim, ch_en, busy, done, pass, sig
    );

    modport slave (
        input  start, ch_sel, vec_cnt, seed, exp_sig, resp,
        output stim, ch_en, busy, done, pass, sig
    );
endinterface

// File: rtl/tt_macro_bist_sequencer.sv
// BIST sequencer for hardened macros: LFSR stimulus into one channel, MISR fold of
// that channel's response after LAT cycles, signature compare at the end of the run.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; run parameters latched on start
// S_RUN   | one stimulus vector per cycle, vec_cnt cycles
// S_DRAIN | LAT cycles collecting the responses still in the macro
// S_DONE  | one cycle: done pulse, signature compared against exp_sig
module tt_macro_bist_sequencer #(
    parameter int                N_CH   = 4,
    parameter int                DATA_W = 8,
    parameter int                CNT_W  = 8,
    parameter int                LAT    = 1,
    parameter logic [DATA_W-1:0] TAPS   = 8'hB8
) (
    input  logic                    clk,
    input  logic                    rst,
    tt_macro_bist_sequencer_if.slave bus
);
    localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    // LAT=0 still gets a one-bit pipe so the vector has a legal width; it stays 0.
    localparam int PW    = (LAT > 0) ? LAT : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          drn_q, drn_d;
    logic [DATA_W-1:0]   lfsr_q, lfsr_d;
    logic [DATA_W-1:0]   sig_q, sig_d;
    logic [SEL_W-1:0]    ch_q, ch_d;
    logic                ch_ok_q, ch_ok_d;
    logic                pass_q, pass_d;
    logic [PW-1:0]       vld_q, vld_d;

    logic                sel_ok;
    logic                issue;
    logic                tap;
    logic                cmp;
    logic [DATA_W-1:0]   resp_sel;

    function automatic logic [DATA_W-1:0] galois_step(input logic [DATA_W-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : '0);
    endfunction

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drn_d    = drn_q;
        lfsr_d   = lfsr_q;
        sig_d    = sig_q;
        ch_d     = ch_q;
        ch_ok_d  = ch_ok_q;
        pass_d   = pass_q;
        resp_sel = '0;
        bus.stim  = '0;
        bus.ch_en = '0;

        sel_ok = (int'(bus.ch_sel) < N_CH);
        issue  = (state_q == S_RUN);
        tap    = (LAT == 0) ? issue : vld_q[PW-1];
        vld_d  = (LAT == 0) ? '0 : ((vld_q << 1) | PW'(issue));
        cmp    = ch_ok_q && (sig_q == bus.exp_sig);

        for (int c = 0; c < N_CH; c++) begin
            if (c == int'(ch_q)) begin
                resp_sel = bus.resp[c*DATA_W +: DATA_W];
                if (state_q == S_RUN) begin
                    bus.stim[c*DATA_W +: DATA_W] = lfsr_q;
                end
                if ((state_q == S_RUN) || (state_q == S_DRAIN)) begin
                    bus.ch_en[c] = 1'b1;
                end
            end
        end

        // The valid tap can only be set in RUN/DRAIN; the state guard keeps
        // stray responses out of the signature in IDLE/DONE regardless.
        if (tap && ((state_q == S_RUN) || (state_q == S_DRAIN))) begin
            sig_d = galois_step(sig_q) ^ resp_sel;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sig_d   = '0;
                    pass_d  = 1'b0;
                    lfsr_d  = (bus.seed == '0) ? DATA_W'(1) : bus.seed;
                    cnt_d   = bus.vec_cnt;
                    ch_d    = bus.ch_sel;
                    ch_ok_d = sel_ok;
                    vld_d   = '0;
                    state_d = ((bus.vec_cnt != '0) && sel_ok) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                lfsr_d = galois_step(lfsr_q);
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    if (LAT == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        drn_d   = 3'(LAT);
                    end
                end
            end
            S_DRAIN: begin
                drn_d = drn_q - 1'b1;
                if (drn_q == 3'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                pass_d  = cmp;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        bus.busy = (state_q != S_IDLE);
        bus.done = (state_q == S_DONE);
        bus.pass = (state_q == S_DONE) ? cmp : pass_q;
        bus.sig  = sig_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            drn_q   <= '0;
            lfsr_q  <= DATA_W'(1);
            sig_q   <= '0;
            ch_q    <= '0;
            ch_ok_q <= 1'b0;
            pass_q  <= 1'b0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            lfsr_q  <= lfsr_d;
            sig_q   <= sig_d;
            ch_q    <= ch_d;
            ch_ok_q <= ch_ok_d;
            pass_q  <= pass_d;
            vld_q   <= vld_d;
        end
    end
endmodule

// File: tb/tb_tt_macro_bist_sequencer.sv
// Bench for the macro BIST sequencer: two instances (LAT=0 and LAT=1) share the same
// control stimulus; each has a loopback macro on the channel under test and noise on
// the others. A run-level model predicts every output on every cycle.
module tb_tt_macro_bist_sequencer;
    localparam logic [7:0] TAPS = 8'hB8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start   = 1'b0;
    logic [1:0] ch_sel  = '0;
    logic [7:0] vec_cnt = '0;
    logic [7:0] seed    = '0;
    logic [7:0] exp_sig = '0;
    bit         ff_mode = 1'b0;
    bit         chk_en  = 1'b0;
    int         cyc     = 0;
    int         n_cmp   = 0;
    int         n_err   = 0;

    tt_macro_bist_sequencer_if #(.N_CH(4), .DATA_W(8), .CNT_W(8)) if0 ();
    tt_macro_bist_sequencer_if #(.N_CH(4), .DATA_W(8), .CNT_W(8)) if1 ();

    tt_macro_bist_sequencer #(.N_CH(4), .DATA_W(8), .CNT_W(8), .LAT(0), .TAPS(TAPS))
        u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    tt_macro_bist_sequencer #(.N_CH(4), .DATA_W(8), .CNT_W(8), .LAT(1), .TAPS(TAPS))
        u_dut1 (.clk(clk), .rst(rst), .bus(if1));

    // ---------------- run-level model ----------------
    bit         act[2];
    bit         runm[2];
    int         t0[2];
    int         nv[2];
    int         chm[2];
    int         done_c[2];
    logic [7:0] fin_sig[2];
    logic [7:0] held_sig[2];
    bit         fin_pass[2];
    bit         held_pass[2];
    logic [7:0] vals[2][256];
    int         cur_ch[2];

    function automatic logic [7:0] lstep(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 8'h00);
    endfunction

    function automatic logic [7:0] calc_sig(input logic [7:0] sd, input int n);
        logic [7:0] v, s;
        v = (sd == 8'h00) ? 8'h01 : sd;
        s = 8'h00;
        for (int k = 0; k < n; k++) begin
            s = lstep(s) ^ v;
            v = lstep(v);
        end
        return s;
    endfunction

    function automatic bit idle(input int d);
        return !act[d] || (cyc > done_c[d]);
    endfunction

    task automatic accept(input int d, input logic [7:0] sd, input int n, input int ch,
                          input logic [7:0] ex);
        logic [7:0] v;
        if (act[d]) begin
            held_sig[d]  = fin_sig[d];
            held_pass[d] = fin_pass[d];
        end
        act[d]  = 1'b1;
        t0[d]   = cyc;
        nv[d]   = n;
        chm[d]  = ch;
        runm[d] = (ch < 4) && (n != 0);
        v = (sd == 8'h00) ? 8'h01 : sd;
        for (int k = 0; k < n; k++) begin
            vals[d][k] = v;
            v = lstep(v);
        end
        fin_sig[d]  = runm[d] ? calc_sig(sd, n) : 8'h00;
        fin_pass[d] = (ch < 4) && (fin_sig[d] == ex);
        done_c[d]   = runm[d] ? (cyc + n + d + 1) : (cyc + 1);
        cur_ch[d]   = ch;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            act[d]       = 1'b0;
            held_sig[d]  = 8'h00;
            held_pass[d] = 1'b0;
        end
    endtask

    // ---------------- macro models ----------------
    logic [31:0] noise;
    logic [31:0] dly1;
    always @(posedge clk) begin
        noise <= ff_mode ? 32'hFFFF_FFFF : $urandom;
        dly1  <= if1.stim;
    end

    function automatic logic [31:0] build_resp(input logic [31:0] lb, input logic [31:0] nz,
                                               input int ch);
        logic [31:0] r;
        for (int c = 0; c < 4; c++) begin
            r[c*8 +: 8] = (c == ch) ? lb[c*8 +: 8] : nz[c*8 +: 8];
        end
        return r;
    endfunction

    assign if0.resp = build_resp(if0.stim, noise, cur_ch[0]);
    assign if1.resp = build_resp(dly1, noise, cur_ch[1]);

    assign if0.start   = start;
    assign if0.ch_sel  = ch_sel;
    assign if0.vec_cnt = vec_cnt;
    assign if0.seed    = seed;
    assign if0.exp_sig = exp_sig;
    assign if1.start   = start;
    assign if1.ch_sel  = ch_sel;
    assign if1.vec_cnt = vec_cnt;
    assign if1.seed    = seed;
    assign if1.exp_sig = exp_sig;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic chk_dut(input int d, input logic [31:0] st, input logic [3:0] ce,
                           input logic bz, input logic dn, input logic ps, input logic [7:0] sg);
        logic [31:0] es;
        logic [3:0]  ece;
        bit          a;
        int          t;
        a  = act[d];
        t  = t0[d];
        es = '0;
        ece = '0;
        if (a && runm[d] && cyc > t && cyc <= t + nv[d]) es[chm[d]*8 +: 8] = vals[d][cyc-t-1];
        if (a && runm[d] && cyc > t && cyc <= t + nv[d] + d) ece[chm[d]] = 1'b1;
        chk($sformatf("u%0d_stim", d), 64'(st), 64'(es));
        chk($sformatf("u%0d_ch_en", d), 64'(ce), 64'(ece));
        chk($sformatf("u%0d_busy", d), 64'(bz), 64'(a && cyc > t && cyc <= done_c[d]));
        chk($sformatf("u%0d_done", d), 64'(dn), 64'(a && cyc == done_c[d]));
        if (a && cyc > t && cyc < done_c[d]) begin
            chk($sformatf("u%0d_pass_run", d), 64'(ps), 64'(0));
        end else if (a && cyc >= done_c[d]) begin
            chk($sformatf("u%0d_sig", d), 64'(sg), 64'(fin_sig[d]));
            chk($sformatf("u%0d_pass", d), 64'(ps), 64'(fin_pass[d]));
        end else begin
            chk($sformatf("u%0d_sig_held", d), 64'(sg), 64'(held_sig[d]));
            chk($sformatf("u%0d_pass_held", d), 64'(ps), 64'(held_pass[d]));
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk_dut(0, if0.stim, if0.ch_en, if0.busy, if0.done, if0.pass, if0.sig);
            chk_dut(1, if1.stim, if1.ch_en, if1.busy, if1.done, if1.pass, if1.sig);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] sd, input int n, input int ch,
                             input logic [7:0] ex);
        seed    = sd;
        vec_cnt = 8'(n);
        ch_sel  = 2'(ch);
        exp_sig = ex;
        start   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (idle(d)) accept(d, sd, n, ch, ex);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (!(idle(0) && idle(1)) && k < 600) begin
            tick();
            k++;
        end
        if (k >= 600) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: still busy after %0d cycles (cycle %0d)", k, cyc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] sd, ex;
        int n, ch, r;

        model_reset();
        cur_ch[0] = 0;
        cur_ch[1] = 0;
        repeat (3) tick();
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(if1.busy), 64'(0));
        chk("reset_sig", 64'(if1.sig), 64'(0));
        tick();

        // Case 1: seed 01, 3 vectors, channel 0, expected 5C.
        start_run(8'h01, 3, 0, 8'h5C);
        chk("model_vals_c1", 64'({vals[1][0], vals[1][1], vals[1][2]}), 64'(24'h01B85C));
        chk("model_done_c1", 64'(done_c[1] - t0[1]), 64'(5));
        @(negedge clk);
        chk("c1_stim_first", 64'(if1.stim[7:0]), 64'(8'h01));
        wait_idle();
        @(negedge clk);
        chk("c1_sig_lat1", 64'(if1.sig), 64'(8'h5C));
        chk("c1_pass_lat1", 64'(if1.pass), 64'(1));
        chk("c1_sig_lat0", 64'(if0.sig), 64'(8'h5C));
        tick();

        // Case 2: wrong expectation, then correct one again.
        start_run(8'h01, 3, 0, 8'h5D);
        wait_idle();
        @(negedge clk);
        chk("c2_pass_bad", 64'(if1.pass), 64'(0));
        chk("c2_sig", 64'(if1.sig), 64'(8'h5C));
        tick();
        start_run(8'h01, 3, 0, 8'h5C);
        wait_idle();
        @(negedge clk);
        chk("c2_pass_good", 64'(if1.pass), 64'(1));
        tick();

        // Case 3: zero seed, 5 vectors.
        start_run(8'h00, 5, 1, 8'h17);
        chk("model_vals_c3", 64'({vals[0][0], vals[0][1], vals[0][2], vals[0][3], vals[0][4]}),
            64'(40'h01B85C2E17));
        chk("model_done_c3", 64'(done_c[0] - t0[0]), 64'(6));
        wait_idle();
        @(negedge clk);
        chk("c3_sig_lat0", 64'(if0.sig), 64'(8'h17));
        chk("c3_pass_lat0", 64'(if0.pass), 64'(1));
        tick();

        // Case 4: channel 2 with FF on every other channel's response.
        ff_mode = 1'b1;
        tick();
        start_run(8'h01, 3, 2, 8'h5C);
        wait_idle();
        @(negedge clk);
        chk("c4_sig_lat1", 64'(if1.sig), 64'(8'h5C));
        tick();
        ff_mode = 1'b0;

        // Case 5: zero-length run, then a start pulse ignored while running.
        start_run(8'h33, 0, 1, 8'h00);
        chk("model_done_c5", 64'(done_c[1] - t0[1]), 64'(1));
        wait_idle();
        @(negedge clk);
        chk("c5_pass", 64'(if1.pass), 64'(1));
        tick();
        start_run(8'h5A, 10, 3, calc_sig(8'h5A, 10));
        repeat (3) tick();
        ch_sel = 2'd0; vec_cnt = 8'd2; seed = 8'h77; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        tick();

        // Case 6: reset after two vectors, then a clean run.
        start_run(8'hC3, 8, 1, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("c6_busy", 64'(if1.busy), 64'(0));
        chk("c6_stim", 64'(if1.stim), 64'(0));
        chk("c6_sig", 64'(if1.sig), 64'(0));
        chk("c6_pass", 64'(if1.pass), 64'(0));
        tick();
        start_run(8'h01, 3, 0, 8'h5C);
        wait_idle();
        tick();

        // Randomized runs with ignored start pulses and occasional resets.
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 2)) tick();
            n  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 255))
                                              : int'($urandom_range(0, 16));
            sd = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ch = int'($urandom_range(0, 3));
            ex = $urandom_range(0, 1) ? calc_sig(sd, n) : 8'($urandom);
            start_run(sd, n, ch, ex);
            for (int k = 0; k < 600 && !(idle(0) && idle(1)); k++) begin
                r = int'($urandom_range(0, 31));
                if (r == 0 && !idle(0) && !idle(1)) begin
                    ch_sel = 2'($urandom); vec_cnt = 8'($urandom); seed = 8'($urandom);
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                end else if (r == 1 && (it % 4) == 0) begin
                    do_reset();
                end else begin
                    tick();
                end
            end
            wait_idle();
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
